// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants, segment table and phase type for the seven-segment scanner.
package seg_pkg;

    // All segments dark (active-low) and all anodes off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value 0..F.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Slot phase: anti-ghosting blank interval, then the digit is lit.
    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_t;

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed common-anode display scanner with per-slot blanking,
// once-per-frame input latching and optional leading-zero suppression.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int DWELL_CYCLES    = 100000,
    parameter int BLANK_CYCLES    = 1000,
    parameter int LEAD_ZERO_BLANK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] display_in,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int            CW         = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] c;
    logic [1:0]    d;
    phase_t        phase;
    phase_t        phase_next;
    logic [15:0]   val_q;
    logic [3:0]    dp_q;

    logic          frame_start;
    logic [3:0]    suppress;
    logic [6:0]    digit_seg;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          dp_next;

    assign frame_start = (c == '0) && (d == 2'd0);

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (val_q[{d, 2'b00} +: 4]),
        .seg    (digit_seg)
    );

    // Slot counter and digit index; the digit advances only when a slot completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
            d <= 2'd0;
        end else if (c == SLOT_LAST) begin
            c <= '0;
            d <= d + 2'd1;
        end else begin
            c <= c + 1'b1;
        end
    end

    // Phase register tracks whether the current count is past the blank interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_BLANK;
        end else begin
            phase <= phase_next;
        end
    end

    // Enter ON once the blank interval has elapsed, return to BLANK at slot end.
    always_comb begin
        phase_next = phase;
        if (c == SLOT_LAST) begin
            phase_next = PH_BLANK;
        end else if (c == BLANK_LAST) begin
            phase_next = PH_ON;
        end
    end

    // Latch the value and point mask at frame start so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= 16'h0000;
            dp_q  <= 4'h0;
        end else if (frame_start) begin
            val_q <= display_in;
            dp_q  <= dp_in;
        end
    end

    // A digit is hidden when it and every digit above it are zero, unless its point is requested.
    always_comb begin
        suppress = 4'b0000;
        if (LEAD_ZERO_BLANK != 0) begin
            suppress[3] = (val_q[15:12] == 4'h0)  && !dp_q[3];
            suppress[2] = (val_q[15:8]  == 8'h0)  && !dp_q[2];
            suppress[1] = (val_q[15:4]  == 12'h0) && !dp_q[1];
        end
    end

    // Output values for the current count; everything dark unless the digit is lit.
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (phase == PH_ON && !suppress[d]) begin
            an_next     = AN_OFF;
            an_next[d]  = 1'b0;
            seg_next    = digit_seg;
            dp_next     = ~dp_q[d];
        end
    end

    // Registered outputs keep the pins glitch-free and isolated from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_tick <= frame_start;
        end
    end

endmodule
